// File: rtl/traffic_analyzer_gmii_capture_ctrl_pkg.sv
// Shared definitions for the GMII frame capture controller:
// state encoding, frame_size_reg layout and byte-lane helpers.
package traffic_analyzer_gmii_capture_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_ARMED,
      S_CAPTURE,
      S_WAIT_STATUS,
      S_DONE
   } cap_state_t;

   localparam int FS_TRUNC     = 31;
   localparam int FS_CRC_BAD   = 30;
   localparam int FS_TIMEOUT   = 29;
   localparam int FS_COUNT_MSB = 15;
   localparam int FS_COUNT_LSB = 0;

   // Byte enables for a word holding n bytes; byte 0 sits in [31:24].
   function automatic logic [3:0] lane_mask(input logic [1:0] n);
      logic [3:0] m;
      unique case (n)
         2'd1:    m = 4'h8;
         2'd2:    m = 4'hC;
         2'd3:    m = 4'hE;
         default: m = 4'hF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/traffic_analyzer_gmii_capture_ctrl_byte_packer.sv
// Stages received bytes into 32-bit words and issues full-word
// writes and partial flushes to the frame buffer RAM.
module traffic_analyzer_gmii_byte_packer
   import traffic_analyzer_gmii_capture_ctrl_pkg::*;
#(
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clear,
   input  logic          store,
   input  logic          flush,
   input  logic [1:0]    lane,
   input  logic [7:0]    rxd,
   input  logic [AW-1:0] word_addr,
   output logic          buf_we,
   output logic [AW-1:0] buf_waddr,
   output logic [31:0]   buf_wdata,
   output logic [3:0]    buf_wbe
);

   logic [31:0] stage;
   logic [31:0] stage_nxt;

   // Lane 0 starts a fresh word so unfilled lanes read as zero.
   always_comb begin
      stage_nxt = (lane == 2'd0) ? 32'h0 : stage;
      unique case (lane)
         2'd0: stage_nxt[31:24] = rxd;
         2'd1: stage_nxt[23:16] = rxd;
         2'd2: stage_nxt[15:8]  = rxd;
         default: stage_nxt[7:0] = rxd;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stage     <= '0;
         buf_we    <= 1'b0;
         buf_waddr <= '0;
         buf_wdata <= '0;
         buf_wbe   <= '0;
      end else begin
         buf_we  <= 1'b0;
         buf_wbe <= '0;
         if (clear) begin
            stage <= '0;
         end else if (store) begin
            stage <= stage_nxt;
            if (lane == 2'd3) begin
               buf_we    <= 1'b1;
               buf_wbe   <= 4'hF;
               buf_waddr <= word_addr;
               buf_wdata <= stage_nxt;
            end
         end else if (flush && lane != 2'd0) begin
            buf_we    <= 1'b1;
            buf_wbe   <= lane_mask(lane);
            buf_waddr <= word_addr;
            buf_wdata <= stage;
         end
      end
   end

endmodule

// File: rtl/traffic_analyzer_gmii_capture_ctrl.sv
// Single-frame GMII capture sequencer: arm, sync to a frame start,
// pack into the frame buffer, publish size, optional bad-CRC filter.
module traffic_analyzer_gmii_capture_ctrl
   import traffic_analyzer_gmii_capture_ctrl_pkg::*;
#(
   parameter int C_FRAME_BUF_ADDRESS_WIDTH = 9,
   parameter int C_STATUS_TIMEOUT          = 16
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic                                 gmii_rx_dv,
   input  logic [7:0]                           gmii_rxd,
   input  logic                                 crc_status_valid,
   input  logic                                 crc_status_bad,
   input  logic                                 arm,
   input  logic                                 disarm,
   input  logic                                 filter_bad_crc,
   output logic                                 buf_we,
   output logic [C_FRAME_BUF_ADDRESS_WIDTH-1:0] buf_waddr,
   output logic [31:0]                          buf_wdata,
   output logic [3:0]                           buf_wbe,
   output logic [31:0]                          frame_size_reg,
   output logic                                 capture_done,
   output logic                                 capture_busy
);

   localparam int AW  = C_FRAME_BUF_ADDRESS_WIDTH;
   localparam int CW  = AW + 3;
   localparam int TW  = $clog2(C_STATUS_TIMEOUT) + 1;
   localparam logic [CW-1:0] CAP_CNT  = CW'(1 << (AW + 2));
   localparam logic [TW-1:0] TMO_LAST = TW'(C_STATUS_TIMEOUT - 1);

   cap_state_t    state;
   cap_state_t    nxt;
   logic [CW-1:0] count;
   logic          trunc;
   logic [TW-1:0] tmo_cnt;
   logic          clr;
   logic          store;
   logic          flush;
   logic          fs_load;
   logic          tmo_hit;
   logic          full;
   logic [31:0]   fs_new;

   assign full = (count == CAP_CNT);

   always_comb begin
      nxt     = state;
      clr     = 1'b0;
      store   = 1'b0;
      flush   = 1'b0;
      fs_load = 1'b0;
      tmo_hit = 1'b0;
      if (disarm) begin
         nxt = S_IDLE;
      end else if (arm) begin
         nxt = S_SYNC;
         clr = 1'b1;
      end else begin
         unique case (state)
            S_SYNC: begin
               if (!gmii_rx_dv) nxt = S_ARMED;
            end
            S_ARMED: begin
               if (gmii_rx_dv) begin
                  nxt   = S_CAPTURE;
                  store = 1'b1;
               end
            end
            S_CAPTURE: begin
               if (gmii_rx_dv) begin
                  store = 1'b1;
               end else begin
                  flush = 1'b1;
                  nxt   = S_WAIT_STATUS;
               end
            end
            S_WAIT_STATUS: begin
               if (crc_status_valid) begin
                  if (filter_bad_crc && !crc_status_bad) begin
                     nxt = S_SYNC;
                     clr = 1'b1;
                  end else begin
                     nxt     = S_DONE;
                     fs_load = 1'b1;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  nxt     = S_DONE;
                  fs_load = 1'b1;
                  tmo_hit = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      fs_new = '0;
      fs_new[FS_TRUNC]   = trunc;
      fs_new[FS_CRC_BAD] = crc_status_bad & ~tmo_hit;
      fs_new[FS_TIMEOUT] = tmo_hit;
      fs_new[FS_COUNT_MSB:FS_COUNT_LSB] = 16'(count);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= nxt;
   end

   // Count saturates at capacity; overflow bytes only mark truncation.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count          <= '0;
         trunc          <= 1'b0;
         tmo_cnt        <= '0;
         frame_size_reg <= '0;
         capture_done   <= 1'b0;
      end else begin
         if (clr) begin
            count <= '0;
            trunc <= 1'b0;
         end else if (store) begin
            if (full) trunc <= 1'b1;
            else      count <= count + 1'b1;
         end
         if (state == S_WAIT_STATUS) tmo_cnt <= tmo_cnt + 1'b1;
         else                        tmo_cnt <= '0;
         if (disarm) begin
            capture_done <= 1'b0;
         end else if (arm) begin
            capture_done   <= 1'b0;
            frame_size_reg <= '0;
         end else if (fs_load) begin
            capture_done   <= 1'b1;
            frame_size_reg <= fs_new;
         end
      end
   end

   assign capture_busy = (state != S_IDLE) && (state != S_DONE);

   traffic_analyzer_gmii_byte_packer #(
      .AW(AW)
   ) u_packer (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (clr),
      .store    (store && !full),
      .flush    (flush),
      .lane     (count[1:0]),
      .rxd      (gmii_rxd),
      .word_addr(count[AW+1:2]),
      .buf_we   (buf_we),
      .buf_waddr(buf_waddr),
      .buf_wdata(buf_wdata),
      .buf_wbe  (buf_wbe)
   );

endmodule

// File: tb/tb_traffic_analyzer_gmii_capture_ctrl.sv
// Directed + randomized bench for the GMII capture controller; two
// instances (2 KiB and 64 B buffers) share stimulus, checked vs a model.
module tb_traffic_analyzer_gmii_capture_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn, rx_dv, crc_v, crc_bad, arm, disarm, filt;
   logic [7:0] rxd;

   logic        we9, done9, busy9;
   logic [8:0]  waddr9;
   logic [31:0] wdata9, fsz9;
   logic [3:0]  wbe9;
   logic        we4, done4, busy4;
   logic [3:0]  waddr4;
   logic [31:0] wdata4, fsz4;
   logic [3:0]  wbe4;

   traffic_analyzer_gmii_capture_ctrl #(
      .C_FRAME_BUF_ADDRESS_WIDTH(9), .C_STATUS_TIMEOUT(16)
   ) dut9 (
      .clk(clk), .resetn(resetn), .gmii_rx_dv(rx_dv), .gmii_rxd(rxd),
      .crc_status_valid(crc_v), .crc_status_bad(crc_bad),
      .arm(arm), .disarm(disarm), .filter_bad_crc(filt),
      .buf_we(we9), .buf_waddr(waddr9), .buf_wdata(wdata9),
      .buf_wbe(wbe9), .frame_size_reg(fsz9),
      .capture_done(done9), .capture_busy(busy9)
   );

   traffic_analyzer_gmii_capture_ctrl #(
      .C_FRAME_BUF_ADDRESS_WIDTH(4), .C_STATUS_TIMEOUT(16)
   ) dut4 (
      .clk(clk), .resetn(resetn), .gmii_rx_dv(rx_dv), .gmii_rxd(rxd),
      .crc_status_valid(crc_v), .crc_status_bad(crc_bad),
      .arm(arm), .disarm(disarm), .filter_bad_crc(filt),
      .buf_we(we4), .buf_waddr(waddr4), .buf_wdata(wdata4),
      .buf_wbe(wbe4), .frame_size_reg(fsz4),
      .capture_done(done4), .capture_busy(busy4)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] mem9 [0:511];
   logic [31:0] mem4 [0:511];
   int          alog9 [0:4095];
   int          alog4 [0:4095];
   logic [3:0]  blog9 [0:4095];
   logic [3:0]  blog4 [0:4095];
   int          wr9 = 0;
   int          wr4 = 0;
   logic [7:0]  fb [0:255];

   // RAM model and write log, sampled just after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (we9 === 1'b1 && wr9 < 4096) begin
         for (int l = 0; l < 4; l++)
            if (wbe9[3-l]) mem9[waddr9][31-8*l -: 8] = wdata9[31-8*l -: 8];
         alog9[wr9] = int'(waddr9);
         blog9[wr9] = wbe9;
         wr9++;
      end
      if (we4 === 1'b1 && wr4 < 4096) begin
         for (int l = 0; l < 4; l++)
            if (wbe4[3-l]) mem4[waddr4][31-8*l -: 8] = wdata4[31-8*l -: 8];
         alog4[wr4] = int'(waddr4);
         blog4[wr4] = wbe4;
         wr4++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
   endtask

   task automatic send(input int len, input int arm_at);
      for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
      for (int i = 0; i < len; i++) begin
         rx_dv = 1'b1;
         rxd   = fb[i];
         arm   = (i == arm_at);
         tick();
      end
      arm   = 1'b0;
      rx_dv = 1'b0;
      rxd   = 8'h00;
   endtask

   task automatic status(input int d, input logic bad);
      tick(d);
      crc_v   = 1'b1;
      crc_bad = bad;
      tick();
      crc_v   = 1'b0;
      crc_bad = 1'b0;
   endtask

   // Expected result from frame length, buffer capacity and status.
   task automatic expect_frame(input string tag, input bit big,
                               input int len, input logic bad,
                               input logic to, input int ws);
      int cap, n, nw, errs, cerr, wr;
      logic [31:0] efs, fs, word;
      logic [3:0] ewbe, bl;
      logic dn, bs;
      cap = big ? 2048 : 64;
      n   = (len < cap) ? len : cap;
      nw  = (n + 3) / 4;
      efs = {(len > cap) ? 1'b1 : 1'b0, bad & ~to, to, 13'b0, 16'(n)};
      fs  = big ? fsz9 : fsz4;
      dn  = big ? done9 : done4;
      bs  = big ? busy9 : busy4;
      wr  = big ? wr9 : wr4;
      chk({tag, "_fsz"}, fs, efs);
      chk({tag, "_done"}, 32'(dn), 32'd1);
      chk({tag, "_busy"}, 32'(bs), 32'd0);
      chk({tag, "_nwr"}, 32'(wr - ws), 32'(nw));
      errs = 0;
      for (int j = 0; j < nw && ws + j < wr; j++) begin
         ewbe = 4'hF;
         if (j == nw - 1 && (n % 4) != 0)
            ewbe = 4'hF << (4 - (n % 4));
         bl = big ? blog9[ws+j] : blog4[ws+j];
         if ((big ? alog9[ws+j] : alog4[ws+j]) != j) errs++;
         if (bl !== ewbe) errs++;
      end
      chk({tag, "_wrseq"}, 32'(errs), 32'd0);
      cerr = 0;
      for (int i = 0; i < n; i++) begin
         word = big ? mem9[i/4] : mem4[i/4];
         if (word[31-8*(i%4) -: 8] !== fb[i]) cerr++;
      end
      chk({tag, "_data"}, 32'(cerr), 32'd0);
   endtask

   initial begin
      int s9, s4, len, d;
      logic bad, f;
      resetn = 1'b0; rx_dv = 1'b0; rxd = 8'h00; crc_v = 1'b0;
      crc_bad = 1'b0; arm = 1'b0; disarm = 1'b0; filt = 1'b0;
      tick(3);
      chk("rst_we9", 32'(we9), 32'd0);
      chk("rst_fsz9", fsz9, 32'd0);
      chk("rst_done9", 32'(done9), 32'd0);
      chk("rst_busy9", 32'(busy9), 32'd0);
      chk("rst_we4", 32'(we4), 32'd0);
      resetn = 1'b1;
      tick(2);

      // 64-byte good frame
      s9 = wr9; s4 = wr4;
      do_arm();
      chk("arm_busy", 32'(busy9), 32'd1);
      send(64, -1);
      status(3, 1'b0);
      expect_frame("f64_9", 1'b1, 64, 1'b0, 1'b0, s9);
      expect_frame("f64_4", 1'b0, 64, 1'b0, 1'b0, s4);

      // 66-byte bad frame: partial final word
      s9 = wr9; s4 = wr4;
      do_arm();
      send(66, -1);
      status(5, 1'b1);
      expect_frame("f66_9", 1'b1, 66, 1'b1, 1'b0, s9);
      expect_frame("f66_4", 1'b0, 66, 1'b1, 1'b0, s4);
      chk("f66_wdata", {16'h0, wdata9[31:16]}, {16'h0, fb[64], fb[65]});

      // arm while a frame is on the wire
      s9 = wr9;
      tick();
      send(40, 10);
      chk("mid_nowr", 32'(wr9 - s9), 32'd0);
      chk("mid_busy", 32'(busy9), 32'd1);
      tick(3);
      s9 = wr9; s4 = wr4;
      send(30, -1);
      status(2, 1'b0);
      expect_frame("mid_9", 1'b1, 30, 1'b0, 1'b0, s9);
      expect_frame("mid_4", 1'b0, 30, 1'b0, 1'b0, s4);

      // overflow of the small buffer
      s9 = wr9; s4 = wr4;
      do_arm();
      send(100, -1);
      status(1, 1'b0);
      expect_frame("f100_9", 1'b1, 100, 1'b0, 1'b0, s9);
      expect_frame("f100_4", 1'b0, 100, 1'b0, 1'b0, s4);

      // bad-CRC filter: good frame re-arms, bad frame is kept
      filt = 1'b1;
      do_arm();
      send(50, -1);
      status(4, 1'b0);
      chk("flt_done", 32'(done9), 32'd0);
      chk("flt_busy", 32'(busy9), 32'd1);
      chk("flt_done4", 32'(done4), 32'd0);
      tick(2);
      s9 = wr9; s4 = wr4;
      send(70, -1);
      status(6, 1'b1);
      expect_frame("flt_9", 1'b1, 70, 1'b1, 1'b0, s9);
      expect_frame("flt_4", 1'b0, 70, 1'b1, 1'b0, s4);
      filt = 1'b0;

      // status pulse in DONE is ignored
      crc_v = 1'b1; crc_bad = 1'b0;
      tick();
      crc_v = 1'b0;
      tick();
      chk("done_ign", fsz9, 32'h4000_0046);

      // randomized frames, lengths and status delays
      for (int k = 0; k < 10; k++) begin
         len  = $urandom_range(1, 140);
         bad  = 1'($urandom_range(0, 1));
         f    = 1'($urandom_range(0, 1));
         d    = $urandom_range(1, 16);
         filt = f;
         s9 = wr9; s4 = wr4;
         do_arm();
         send(len, -1);
         status(d, bad);
         if (f && !bad) begin
            chk("rnd_rearm", 32'(done9), 32'd0);
            chk("rnd_rebusy", 32'(busy4), 32'd1);
            disarm = 1'b1;
            tick();
            disarm = 1'b0;
         end else begin
            expect_frame("rnd_9", 1'b1, len, bad, 1'b0, s9);
            expect_frame("rnd_4", 1'b0, len, bad, 1'b0, s4);
         end
      end
      filt = 1'b0;

      // status timeout
      s9 = wr9; s4 = wr4;
      do_arm();
      send(20, -1);
      tick(16);
      chk("tmo_early", 32'(done9), 32'd0);
      tick();
      expect_frame("tmo_9", 1'b1, 20, 1'b0, 1'b1, s9);
      expect_frame("tmo_4", 1'b0, 20, 1'b0, 1'b1, s4);
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
      chk("disarm_done", 32'(done9), 32'd0);
      chk("disarm_busy", 32'(busy9), 32'd0);

      // arm and disarm together: disarm wins
      arm = 1'b1; disarm = 1'b1;
      tick();
      arm = 1'b0; disarm = 1'b0;
      chk("both_busy", 32'(busy9), 32'd0);

      // asynchronous reset mid-capture
      do_arm();
      for (int i = 0; i < 4; i++) begin
         rx_dv = 1'b1;
         rxd   = 8'(i);
         tick();
      end
      chk("pre_rst_we", 32'(we9), 32'd1);
      #1 resetn = 1'b0;
      #1;
      chk("rst_mid_we9", 32'(we9), 32'd0);
      chk("rst_mid_we4", 32'(we4), 32'd0);
      chk("rst_mid_busy", 32'(busy9), 32'd0);
      tick(2);
      rx_dv  = 1'b0;
      resetn = 1'b1;
      tick(2);
      chk("post_rst_busy", 32'(busy9), 32'd0);
      chk("post_rst_done", 32'(done9), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_analyzer_gmii_capture_ctrl.md
Name: traffic_analyzer_gmii_capture_ctrl

Overview:
- Sequences single-frame capture from the analyzer's GMII receive path into the frame buffer RAM (dual-port RAM; CPU side is read by the register block via frame_buf_address).
- CPU arms a capture. The block waits for a clean frame start, packs bytes into 32-bit words and writes them to RAM, then publishes frame_size and holds the buffer until the next arm.
- An optional filter captures only CRC-bad frames; a non-matching frame re-arms automatically.

Parameters:
- C_FRAME_BUF_ADDRESS_WIDTH, 9, RAM word-address width; capacity = 4*2^AW bytes.
- C_STATUS_TIMEOUT, 16, max clk cycles from rx_dv fall to crc_status_valid.

Ports:
- clk  in  1  GMII receive clock; sole clock.
- resetn  in  1  asynchronous, active-low reset.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rxd  in  8  receive byte.
- crc_status_valid  in  1  one-cycle pulse from the CRC checker after frame end.
- crc_status_bad  in  1  qualifies crc_status_valid; 1 means bad FCS.
- arm  in  1  one-cycle pulse: start a new capture.
- disarm  in  1  one-cycle pulse: abort and go idle.
- filter_bad_crc  in  1  0 = capture any frame; 1 = capture only CRC-bad frames.
- buf_we  out  1  RAM write enable.
- buf_waddr  out  AW  RAM word address.
- buf_wdata  out  32  packed bytes; byte 0 in [31:24].
- buf_wbe  out  4  byte enables; bit3 covers [31:24].
- frame_size_reg  out  32  bit31 truncated, bit30 crc_bad, bit29 status_timeout, [15:0] captured byte count, other bits 0.
- capture_done  out  1  level; a valid frame is in the buffer.
- capture_busy  out  1  level; state is not IDLE and not DONE.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0; internal byte counter and word staging cleared.
- States: IDLE, SYNC, ARMED, CAPTURE, WAIT_STATUS, DONE.
- Any state + arm → SYNC. Clears capture_done, frame_size_reg and counters.
- Any state + disarm → IDLE. Clears capture_done. If arm and disarm coincide, disarm wins.
- SYNC: wait for gmii_rx_dv=0, so capture never starts mid-frame. Then → ARMED.
- ARMED: on the first cycle with gmii_rx_dv=1 → CAPTURE; that byte is byte 0. Preamble and SFD are captured raw.
- CAPTURE: every cycle with rx_dv=1 stores the byte into the staging word at lane (count mod 4).
  - On the 4th lane, the next cycle drives buf_we=1, buf_wbe=4'hF, buf_waddr = count/4. Write latency is 1 cycle after the last byte of a word.
  - count increments only while count < 4*2^AW. Bytes beyond capacity are dropped and set the truncated flag. count saturates at capacity; the 16-bit field covers capacity up to 65535 bytes.
- rx_dv falls in CAPTURE: flush any partial word in the next cycle with buf_wbe covering only the filled lanes (e.g. 2 bytes → 4'hC), then → WAIT_STATUS. A flush and a full-word write never collide because they need distinct cycles.
- WAIT_STATUS on crc_status_valid:
  - filter_bad_crc=1 and crc_status_bad=0 → SYNC (auto re-arm; counters cleared).
  - Otherwise → DONE. Latch frame_size_reg = {truncated, crc_status_bad, 1'b0, 13'b0, count} and set capture_done the same edge.
- WAIT_STATUS timeout: no status within C_STATUS_TIMEOUT cycles → DONE with bit29=1, bit30=0. The filter is not applied.
- crc_status_valid outside WAIT_STATUS is ignored.
- DONE: buffer is frozen with buf_we=0 and outputs held; leaves only on arm or disarm.
- IDLE/SYNC/ARMED/DONE never assert buf_we.
- rx_dv drop of one cycle ends the frame; a new rx_dv rise while in WAIT_STATUS is not captured.

Decomposition:
- Shared package/defines: state encoding; frame_size_reg bit positions (TRUNC=31, CRC_BAD=30, TIMEOUT=29, COUNT=15:0); byte-lane order (byte 0 → [31:24]).
- One natural sub-module: traffic_analyzer_gmii_byte_packer (byte lane staging, full-word and partial-flush write generation, byte-enable computation). The FSM, counters and filter stay in the top.

Test Plan:
- Arm while idle, then a 64-byte frame (8 preamble/SFD + 56), CRC good. Expect 16 writes, addr 0..15, wbe F. frame_size_reg = 0x00000040, capture_done=1.
- Arm, 66-byte frame, CRC bad. Expect last write addr 16, wbe 4'hC, wdata[31:16] = bytes 64,65. frame_size_reg = 0x40000042.
- Arm while a frame is in progress. Expect no writes for that frame; capture starts at the next frame; byte 0 = its first preamble byte.
- AW=4 (64 B capacity), 100-byte frame. Expect exactly 16 writes, no write beyond addr 15. frame_size_reg = 0x80000040.
- filter_bad_crc=1: good frame, then bad 70-byte frame. Expect the first frame to re-arm with capture_done=0; final frame_size_reg = 0x40000046 and buffer holds the second frame.
- No crc_status_valid after a frame. Expect DONE after 16 cycles, bit29=1. Then disarm → capture_done=0. Assert resetn low mid-CAPTURE → buf_we=0 immediately, state IDLE.
